// File: rtl/load_store_unit.sv
`default_nettype none
// ============================================================================
// Module   : load_store_unit
// Brief    : Sequences core loads/stores onto a synchronous word RAM, splitting
//            misaligned accesses into two word accesses and extending load data.
// Revision : 1.0
// ============================================================================
module load_store_unit #(
  parameter logic [31:0] DATA_BEGIN = 32'h0001_0000,
  parameter logic [31:0] DATA_END   = 32'h0001_FFFF,
  parameter int          WORD_BITS  = 14
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic                 req_write,
  input  logic [2:0]           req_funct3,
  input  logic [31:0]          req_address,
  input  logic [31:0]          req_wdata,
  output logic                 resp_valid,
  output logic [31:0]          resp_rdata,
  output logic                 resp_fault,
  output logic [WORD_BITS-1:0] mem_word_address,
  output logic [3:0]           mem_byteena,
  output logic [31:0]          mem_wdata,
  output logic                 mem_rden,
  output logic                 mem_wren,
  input  logic [31:0]          mem_rdata
);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    ACC0 = 3'd1,
    ACC1 = 3'd2,
    CAP  = 3'd3,
    DONE = 3'd4
  } state_t;

  state_t               r_state;
  state_t               w_next;
  logic                 r_write;
  logic [2:0]           r_funct3;
  logic [1:0]           r_offset;
  logic [WORD_BITS-1:0] r_word_addr;
  logic [7:0]           r_mask;
  logic [63:0]          r_data;
  logic [31:0]          r_lo_buf;
  logic [31:0]          r_hi_buf;
  logic                 r_fault;

  logic                 w_accept;
  logic [3:0]           w_base;
  logic [32:0]          w_size;
  logic [32:0]          w_last;
  logic                 w_fault;
  logic                 w_split;
  logic [WORD_BITS-1:0] w_hi_addr;
  logic [31:0]          w_merged;
  logic [31:0]          w_load;

  assign req_ready = (r_state == IDLE);
  assign w_accept  = req_valid & req_ready;

  always_comb begin
    w_base = 4'b1111;
    w_size = 33'd4;
    case (req_funct3[1:0])
      2'b00:   begin w_base = 4'b0001; w_size = 33'd1; end
      2'b01:   begin w_base = 4'b0011; w_size = 33'd2; end
      default: ;
    endcase
  end

  // 33-bit end address so a request near 2^32 cannot wrap back into range
  assign w_last  = {1'b0, req_address} + w_size - 33'd1;
  assign w_fault = (&req_funct3[1:0]) | (req_write & req_funct3[2]) |
                   (req_address < DATA_BEGIN) | (w_last > {1'b0, DATA_END});

  assign w_split   = |r_mask[7:4];
  assign w_hi_addr = r_word_addr + {{(WORD_BITS-1){1'b0}}, 1'b1};
  assign w_merged  = 32'({r_hi_buf, r_lo_buf} >> {r_offset, 3'b000});

  always_comb begin
    case (r_funct3)
      3'b000:  w_load = {{24{w_merged[7]}}, w_merged[7:0]};
      3'b001:  w_load = {{16{w_merged[15]}}, w_merged[15:0]};
      3'b100:  w_load = {24'd0, w_merged[7:0]};
      3'b101:  w_load = {16'd0, w_merged[15:0]};
      default: w_load = w_merged;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_write     <= 1'b0;
      r_funct3    <= 3'd0;
      r_offset    <= 2'd0;
      r_word_addr <= '0;
      r_mask      <= 8'd0;
      r_data      <= 64'd0;
      r_lo_buf    <= 32'd0;
      r_hi_buf    <= 32'd0;
      r_fault     <= 1'b0;
    end else begin
      if (w_accept) begin
        r_write     <= req_write;
        r_funct3    <= req_funct3;
        r_offset    <= req_address[1:0];
        r_word_addr <= req_address[WORD_BITS+1:2];
        r_mask      <= {4'b0000, w_base} << req_address[1:0];
        r_data      <= {32'd0, req_wdata} << {req_address[1:0], 3'b000};
        r_fault     <= w_fault;
      end
      // In ACC1 the RAM presents the low word requested during ACC0
      if (r_state == ACC1 && !r_write) begin
        r_lo_buf <= mem_rdata;
      end
      if (r_state == CAP) begin
        if (w_split) r_hi_buf <= mem_rdata;
        else         r_lo_buf <= mem_rdata;
      end
    end
  end

  always_comb begin
    w_next           = r_state;
    mem_rden         = 1'b0;
    mem_wren         = 1'b0;
    mem_byteena      = 4'd0;
    mem_wdata        = 32'd0;
    mem_word_address = '0;
    resp_valid       = 1'b0;
    resp_fault       = 1'b0;
    resp_rdata       = 32'd0;
    case (r_state)
      IDLE: begin
        if (w_accept) w_next = w_fault ? DONE : ACC0;
      end
      ACC0: begin
        mem_word_address = r_word_addr;
        if (r_write) begin
          mem_wren    = 1'b1;
          mem_byteena = r_mask[3:0];
          mem_wdata   = r_data[31:0];
          w_next      = w_split ? ACC1 : DONE;
        end else begin
          mem_rden = 1'b1;
          w_next   = w_split ? ACC1 : CAP;
        end
      end
      ACC1: begin
        mem_word_address = w_hi_addr;
        if (r_write) begin
          mem_wren    = 1'b1;
          mem_byteena = r_mask[7:4];
          mem_wdata   = r_data[63:32];
          w_next      = DONE;
        end else begin
          mem_rden = 1'b1;
          w_next   = CAP;
        end
      end
      CAP: begin
        w_next = DONE;
      end
      DONE: begin
        resp_valid = 1'b1;
        resp_fault = r_fault;
        resp_rdata = (r_fault | r_write) ? 32'd0 : w_load;
        w_next     = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

endmodule
`default_nettype wire
